mov_sequencer: RTL and testbench

//  Parametrised MOV micro-sequencer for the SSM datapath: on a MOV opcode it copies one operand
//  (register, bidirectional I/O port or input-only port) to another over the shared bus.

---
 rtl/mov_sequencer_pkg.sv | 24 ++
 rtl/mov_sequencer_if.sv | 34 +++
 rtl/mov_sequencer_addr_decode.sv | 38 +++
 rtl/mov_sequencer.sv | 150 +++++++++++++++
 tb/tb_mov_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mov_sequencer_pkg.sv
// Shared types for the MOV micro-sequencer: FSM states, operand regions and
// the default MOV opcode.
package ssm_mov_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SRC_DRV,
      ST_DST_WR,
      ST_DST_REL,
      ST_DONE,
      ST_ERR
   } mov_state_t;

   typedef enum logic [1:0] {
      RGN_REG,
      RGN_IO,
      RGN_IN,
      RGN_NONE
   } mov_region_t;

   localparam logic [3:0] MOV_OPCODE = 4'b1010;

endpackage

// File: rtl/mov_sequencer_if.sv
// Control-decoder <-> MOV sequencer bundle: opcode/operands in, bus enables
// and start/busy/done handshake out.
interface mov_sequencer_if #(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned NUM_IO   = 1,
   parameter int unsigned NUM_IN   = 1
);
   logic [OPCODE_W-1:0] fsm_start;
   logic [ADDR_W-1:0]   source;
   logic [ADDR_W-1:0]   dest;
   logic [ADDR_W-1:0]   reg_rd_addr;
   logic [ADDR_W-1:0]   reg_wr_addr;
   logic                reg_out_en;
   logic                reg_in_en;
   logic [NUM_IO-1:0]   io_out_en;
   logic [NUM_IO-1:0]   io_in_en;
   logic [NUM_IN-1:0]   in_out_en;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      output fsm_start, source, dest,
      input  reg_rd_addr, reg_wr_addr, reg_out_en, reg_in_en,
             io_out_en, io_in_en, in_out_en, busy, done, err
   );

   modport slave (
      input  fsm_start, source, dest,
      output reg_rd_addr, reg_wr_addr, reg_out_en, reg_in_en,
             io_out_en, io_in_en, in_out_en, busy, done, err
   );
endinterface

// File: rtl/mov_sequencer_addr_decode.sv
// Operand address decoder: maps an address onto register / bidirectional I/O /
// input-only / unmapped region and rebases it to a port index.
module mov_addr_decode
   import ssm_mov_pkg::*;
#(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned NUM_REGS = 5,
   parameter int unsigned NUM_IO   = 1,
   parameter int unsigned NUM_IN   = 1
) (
   input  logic [ADDR_W-1:0] addr,
   output mov_region_t       region,
   output logic [ADDR_W-1:0] index
);
   // Bounds carry one extra bit so a region ending at 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] IO_BASE = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W:0] IN_BASE = (ADDR_W+1)'(NUM_REGS + NUM_IO);
   localparam logic [ADDR_W:0] IN_END  = (ADDR_W+1)'(NUM_REGS + NUM_IO + NUM_IN);

   logic [ADDR_W:0] addr_x;
   assign addr_x = {1'b0, addr};

   // Classify the address and rebase it to the start of its region.
   always_comb begin
      region = RGN_NONE;
      index  = '0;
      if (addr_x < IO_BASE) begin
         region = RGN_REG;
         index  = addr;
      end else if (addr_x < IN_BASE) begin
         region = RGN_IO;
         index  = addr - IO_BASE[ADDR_W-1:0];
      end else if (addr_x < IN_END) begin
         region = RGN_IN;
         index  = addr - IN_BASE[ADDR_W-1:0];
      end
   end
endmodule

// File: rtl/mov_sequencer.sv
// MOV micro-sequencer: copies one operand to another over the shared bus.
// Optional feature macro MOV_SETTLE_EN stretches SRC_DRV by SETTLE_CYC cycles.
// Outputs are registered from the current state, so they trail the state by one cycle.
module mov_sequencer #(
   parameter int unsigned          ADDR_W     = 6,
   parameter int unsigned          OPCODE_W   = 4,
   parameter logic [OPCODE_W-1:0]  MOV_OPCODE = OPCODE_W'(ssm_mov_pkg::MOV_OPCODE),
   parameter int unsigned          NUM_REGS   = 5,
   parameter int unsigned          NUM_IO     = 1,
   parameter int unsigned          NUM_IN     = 1,
   parameter int unsigned          SETTLE_CYC = 2
) (
   input logic            clock,
   input logic            reset,
   mov_sequencer_if.slave bus
);
   import ssm_mov_pkg::*;

   mov_state_t        state, state_nxt;
   logic [ADDR_W-1:0] src_q, dst_q;
   mov_region_t       src_rgn, dst_rgn;
   logic [ADDR_W-1:0] src_idx, dst_idx;
   logic              settle_last;

   logic [ADDR_W-1:0] reg_rd_addr_d, reg_wr_addr_d;
   logic              reg_out_en_d, reg_in_en_d;
   logic [NUM_IO-1:0] io_out_en_d, io_in_en_d;
   logic [NUM_IN-1:0] in_out_en_d;
   logic              busy_d, done_d, err_d;

   mov_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_IO(NUM_IO), .NUM_IN(NUM_IN))
      u_src_dec (.addr(src_q), .region(src_rgn), .index(src_idx));

   mov_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_IO(NUM_IO), .NUM_IN(NUM_IN))
      u_dst_dec (.addr(dst_q), .region(dst_rgn), .index(dst_idx));

`ifdef MOV_SETTLE_EN
   localparam int unsigned CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   logic [CNT_W-1:0] settle_cnt;

   // Load the settle count on the way into SRC_DRV, count down while there.
   always_ff @(posedge clock) begin
      if (reset)
         settle_cnt <= '0;
      else if (state == ST_LATCH)
         settle_cnt <= CNT_W'(SETTLE_CYC);
      else if (state == ST_SRC_DRV && settle_cnt != '0)
         settle_cnt <= settle_cnt - CNT_W'(1);
   end

   assign settle_last = (settle_cnt == '0);
`else
   assign settle_last = 1'b1;
`endif

   // State register and operand capture on an accepted start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         src_q <= '0;
         dst_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && bus.fsm_start == MOV_OPCODE) begin
            src_q <= bus.source;
            dst_q <= bus.dest;
         end
      end
   end

   // Next-state sequencing; start is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (bus.fsm_start == MOV_OPCODE) state_nxt = ST_LATCH;
         ST_LATCH:   if (src_rgn == RGN_NONE || dst_rgn inside {RGN_IN, RGN_NONE})
                        state_nxt = ST_ERR;
                     else
                        state_nxt = ST_SRC_DRV;
         ST_SRC_DRV: if (settle_last) state_nxt = ST_DST_WR;
         ST_DST_WR:  state_nxt = ST_DST_REL;
         ST_DST_REL: state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         ST_ERR:     state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Decode bus enables and handshake from the current state and operand regions.
   always_comb begin
      reg_rd_addr_d = '0;
      reg_wr_addr_d = '0;
      reg_out_en_d  = 1'b0;
      reg_in_en_d   = 1'b0;
      io_out_en_d   = '0;
      io_in_en_d    = '0;
      in_out_en_d   = '0;
      busy_d        = (state != ST_IDLE);
      done_d        = (state == ST_DONE) || (state == ST_ERR);
      err_d         = (state == ST_ERR);
      if (state inside {ST_SRC_DRV, ST_DST_WR, ST_DST_REL}) begin
         case (src_rgn)
            RGN_REG: begin
               reg_out_en_d  = 1'b1;
               reg_rd_addr_d = src_q;
            end
            RGN_IO:  io_out_en_d = NUM_IO'(1) << src_idx;
            RGN_IN:  in_out_en_d = NUM_IN'(1) << src_idx;
            default: ;
         endcase
      end
      if (state == ST_DST_WR) begin
         case (dst_rgn)
            RGN_REG: begin
               reg_in_en_d   = 1'b1;
               reg_wr_addr_d = dst_q;
            end
            RGN_IO:  io_in_en_d = NUM_IO'(1) << dst_idx;
            default: ;
         endcase
      end
   end

   // Output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.reg_rd_addr <= '0;
         bus.reg_wr_addr <= '0;
         bus.reg_out_en  <= 1'b0;
         bus.reg_in_en   <= 1'b0;
         bus.io_out_en   <= '0;
         bus.io_in_en    <= '0;
         bus.in_out_en   <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
      end else begin
         bus.reg_rd_addr <= reg_rd_addr_d;
         bus.reg_wr_addr <= reg_wr_addr_d;
         bus.reg_out_en  <= reg_out_en_d;
         bus.reg_in_en   <= reg_in_en_d;
         bus.io_out_en   <= io_out_en_d;
         bus.io_in_en    <= io_in_en_d;
         bus.in_out_en   <= in_out_en_d;
         bus.busy        <= busy_d;
         bus.done        <= done_d;
         bus.err         <= err_d;
      end
   end
endmodule

// File: tb/tb_mov_sequencer.sv
// Self-checking bench for mov_sequencer (NUM_REGS=5, NUM_IO=1, NUM_IN=1):
// addresses 0..4 registers, 5 I/O port, 6 input-only port, 7+ unmapped.
module tb_mov_sequencer;

`ifdef MOV_SETTLE_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif
   localparam logic [3:0] MOV = 4'b1010;

   typedef struct {
      logic [5:0] src;
      logic [5:0] dst;
      logic       err;
      int         src_kind;  // 0 reg, 1 io, 2 in
      int         dst_kind;  // 0 reg, 1 io
   } vec_t;

   typedef struct packed {
      logic [5:0] reg_rd_addr;
      logic [5:0] reg_wr_addr;
      logic       reg_out_en;
      logic       reg_in_en;
      logic [0:0] io_out_en;
      logic [0:0] io_in_en;
      logic [0:0] in_out_en;
      logic       busy;
      logic       done;
      logic       err;
   } out_t;

   typedef struct {
      logic err;
      int   start;
      int   lat;
   } sb_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   sb_t  sb[$];
   vec_t vecs[11];

   always #5 clock = ~clock;

   mov_sequencer_if #(.ADDR_W(6), .OPCODE_W(4), .NUM_IO(1), .NUM_IN(1)) bus ();

   mov_sequencer #(
      .ADDR_W(6), .OPCODE_W(4), .MOV_OPCODE(4'b1010),
      .NUM_REGS(5), .NUM_IO(1), .NUM_IN(1), .SETTLE_CYC(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic out_t sample();
      out_t a;
      a.reg_rd_addr = bus.reg_rd_addr;
      a.reg_wr_addr = bus.reg_wr_addr;
      a.reg_out_en  = bus.reg_out_en;
      a.reg_in_en   = bus.reg_in_en;
      a.io_out_en   = bus.io_out_en;
      a.io_in_en    = bus.io_in_en;
      a.in_out_en   = bus.in_out_en;
      a.busy        = bus.busy;
      a.done        = bus.done;
      a.err         = bus.err;
      return a;
   endfunction

   // Expected outputs k cycles after the start-sampling edge.
   function automatic out_t model(vec_t v, int k);
      out_t o = '0;
      if (v.err) begin
         if (k == 1) o.busy = 1'b1;
         if (k == 2) begin o.busy = 1'b1; o.done = 1'b1; o.err = 1'b1; end
      end else begin
         if (k >= 1 && k <= 5 + S) o.busy = 1'b1;
         if (k >= 2 && k <= 4 + S) begin
            case (v.src_kind)
               0: begin o.reg_out_en = 1'b1; o.reg_rd_addr = v.src; end
               1: o.io_out_en = 1'b1;
               default: o.in_out_en = 1'b1;
            endcase
         end
         if (k == 3 + S) begin
            if (v.dst_kind == 0) begin o.reg_in_en = 1'b1; o.reg_wr_addr = v.dst; end
            else o.io_in_en = 1'b1;
         end
         if (k == 5 + S) o.done = 1'b1;
      end
      return o;
   endfunction

   // Advance one cycle, sample after the edge, and retire a scoreboard entry on done.
   task automatic tick();
      sb_t e;
      @(posedge clock);
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_err", 32'(bus.err), 32'(e.err));
            chk("sb_latency", 32'(cyc - e.start), 32'(e.lat));
         end
      end
   endtask

   task automatic push(input logic err, input int start);
      sb_t e;
      e.err   = err;
      e.start = start;
      e.lat   = err ? 2 : 5 + S;
      sb.push_back(e);
   endtask

   task automatic run_move(input vec_t v, input string tag);
      bus.fsm_start = MOV;
      bus.source    = v.src;
      bus.dest      = v.dst;
      push(v.err, cyc + 1);
      tick();
      bus.fsm_start = 4'd0;
      bus.source    = 6'($urandom);
      bus.dest      = 6'($urandom);
      for (int k = 1; k <= 7 + S; k++) begin
         tick();
         chk($sformatf("%s_k%0d", tag, k), 32'(sample()), 32'(model(v, k)));
      end
   endtask

   initial begin
      vec_t rr;
      bus.fsm_start = 4'd0;
      bus.source    = '0;
      bus.dest      = '0;

      vecs[0]  = '{6'd2,  6'd4,  1'b0, 0, 0};
      vecs[1]  = '{6'd6,  6'd5,  1'b0, 2, 1};
      vecs[2]  = '{6'd5,  6'd0,  1'b0, 1, 0};
      vecs[3]  = '{6'd0,  6'd5,  1'b0, 0, 1};
      vecs[4]  = '{6'd3,  6'd3,  1'b0, 0, 0};
      vecs[5]  = '{6'd5,  6'd5,  1'b0, 1, 1};
      vecs[6]  = '{6'd2,  6'd6,  1'b1, 0, 0};
      vecs[7]  = '{6'd7,  6'd1,  1'b1, 0, 0};
      vecs[8]  = '{6'd63, 6'd2,  1'b1, 0, 0};
      vecs[9]  = '{6'd4,  6'd63, 1'b1, 0, 0};
      vecs[10] = '{6'd6,  6'd6,  1'b1, 0, 0};

      // Reset state, with a start request present that must be ignored.
      bus.fsm_start = MOV;
      tick();
      tick();
      chk("reset_outputs", 32'(sample()), 32'd0);
      bus.fsm_start = 4'd0;
      reset = 1'b0;
      tick();
      chk("idle_outputs", 32'(sample()), 32'd0);

      for (int i = 0; i < 11; i++)
         run_move(vecs[i], $sformatf("vec%0d", i));

      // Start held continuously: back-to-back moves with one IDLE cycle between.
      rr = vecs[0];
      bus.fsm_start = MOV;
      bus.source    = rr.src;
      bus.dest      = rr.dst;
      for (int m = 0; m < 3; m++) push(1'b0, cyc + 1 + m * (6 + S));
      tick();
      for (int k = 1; k <= 3 * (6 + S); k++) begin
         tick();
         chk($sformatf("b2b_k%0d", k), 32'(sample()), 32'(model(rr, k % (6 + S))));
         if (k == 2 * (6 + S)) bus.fsm_start = 4'd0;
      end
      chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

      // Reset while the destination is being written.
      bus.fsm_start = MOV;
      bus.source    = rr.src;
      bus.dest      = rr.dst;
      tick();
      bus.fsm_start = 4'd0;
      for (int k = 1; k <= 2 + S; k++) tick();
      chk("abort_pre_reset_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      tick();
      chk("abort_outputs", 32'(sample()), 32'd0);
      reset = 1'b0;
      tick();
      chk("abort_idle", 32'(sample()), 32'd0);
      run_move(vecs[1], "post_abort");

      chk("sb_final_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
